cmd_resp_serializer: RTL and testbench

Transmit-side framer for the UART memory-access path. It pops response words produced by the command executor from the response FIFO, serializes each word MSB-first into bytes, and wraps them in a frame: start byte, data bytes, then an XOR checksum. Frames go to the UART transmitter over a valid/ready byte handshake. It sits between the response FIFO read port and the UART TX byte input, mirroring the byte FIFO → command parser path on the receive side.

---
 rtl/cmd_resp_serializer_if.sv | 24 ++
 rtl/cmd_resp_serializer.sv | 99 +++++++++
 tb/tb_cmd_resp_serializer.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_resp_serializer_if.sv
// Response-FIFO read port plus UART TX byte handshake for the response framer.
`timescale 1ns/1ps
interface cmd_resp_serializer_if #(
   parameter int unsigned DATA_W = 32
);
   logic              resp_fifo_valid;
   logic [DATA_W-1:0] resp_fifo_data;
   logic              resp_fifo_rd_en;
   logic [7:0]        tx_data;
   logic              tx_valid;
   logic              tx_ready;
   logic              busy;
   logic              frame_done;

   modport master (
      input  resp_fifo_valid, resp_fifo_data, tx_ready,
      output resp_fifo_rd_en, tx_data, tx_valid, busy, frame_done
   );

   modport slave (
      output resp_fifo_valid, resp_fifo_data, tx_ready,
      input  resp_fifo_rd_en, tx_data, tx_valid, busy, frame_done
   );
endinterface

// File: rtl/cmd_resp_serializer.sv
// Pops response words and frames them MSB-first as SOF, data bytes, optional XOR checksum
// onto the UART TX valid/ready byte stream.
`timescale 1ns/1ps
module cmd_resp_serializer #(
   parameter int unsigned DATA_W   = 32,
   parameter logic [7:0]  SOF_BYTE = 8'hA5,
   parameter bit          USE_CSUM = 1'b1
) (
   input logic                    clk,
   input logic                    rst_n,
   cmd_resp_serializer_if.master  bus
);
   localparam int unsigned NBYTES = DATA_W / 8;
   localparam int unsigned CNT_W  = $clog2(NBYTES) + 1;

   typedef enum logic [1:0] {IDLE, HDR, DATA, CSUM} state_t;

   state_t            state;
   logic [DATA_W-1:0] shift_reg;
   logic [DATA_W-1:0] shift_nxt;
   logic [CNT_W-1:0]  byte_cnt;
   logic [7:0]        csum;
   logic [7:0]        tx_data_q;
   logic              tx_valid_q;
   logic              busy_q;
   logic              hs;
   logic              last_data;

   assign hs        = tx_valid_q && bus.tx_ready;
   assign shift_nxt = shift_reg << 8;
   assign last_data = (byte_cnt == CNT_W'(NBYTES - 1));

   // Pop strobe is only offered in IDLE, so at most one word is taken per frame.
   assign bus.resp_fifo_rd_en = rst_n && (state == IDLE) && bus.resp_fifo_valid;
   assign bus.frame_done      = hs && ((state == CSUM) ||
                                       ((state == DATA) && last_data && !USE_CSUM));
   assign bus.tx_data         = tx_data_q;
   assign bus.tx_valid        = tx_valid_q;
   assign bus.busy            = busy_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shift_reg  <= '0;
         byte_cnt   <= '0;
         csum       <= 8'h00;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.resp_fifo_valid) begin
                  shift_reg  <= bus.resp_fifo_data;
                  byte_cnt   <= '0;
                  csum       <= 8'h00;
                  tx_data_q  <= SOF_BYTE;
                  tx_valid_q <= 1'b1;
                  busy_q     <= 1'b1;
                  state      <= HDR;
               end
            end
            HDR: begin
               if (hs) begin
                  tx_data_q <= shift_reg[DATA_W-1 -: 8];
                  state     <= DATA;
               end
            end
            DATA: begin
               if (hs) begin
                  csum      <= csum ^ tx_data_q;
                  shift_reg <= shift_nxt;
                  byte_cnt  <= byte_cnt + CNT_W'(1);
                  if (last_data) begin
                     if (USE_CSUM) begin
                        tx_data_q <= csum ^ tx_data_q;
                        state     <= CSUM;
                     end else begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state      <= IDLE;
                     end
                  end else begin
                     tx_data_q <= shift_nxt[DATA_W-1 -: 8];
                  end
               end
            end
            CSUM: begin
               if (hs) begin
                  tx_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_cmd_resp_serializer.sv
// Scoreboard bench: a 32-bit checksummed instance and a 16-bit no-checksum instance
// are fed from queue-modelled FIFOs; expected frames are computed per pushed word.
`timescale 1ns/1ps
module tb_cmd_resp_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cmd_resp_serializer_if #(.DATA_W(32)) b32 ();
   cmd_resp_serializer_if #(.DATA_W(16)) b16 ();

   cmd_resp_serializer #(.DATA_W(32), .SOF_BYTE(8'hA5), .USE_CSUM(1'b1)) dut32 (
      .clk(clk), .rst_n(rst_n), .bus(b32));
   cmd_resp_serializer #(.DATA_W(16), .SOF_BYTE(8'hA5), .USE_CSUM(1'b0)) dut16 (
      .clk(clk), .rst_n(rst_n), .bus(b16));

   int checks = 0;
   int passed = 0;
   logic [31:0] fifo32[$];
   logic [15:0] fifo16[$];
   logic [8:0]  exp32[$];
   logic [8:0]  exp16[$];
   bit   pop32 = 1'b0, pop16 = 1'b0;
   int   rd32_cnt = 0, rd16_cnt = 0, hs32_cnt = 0;
   bit   stall32 = 1'b0, stall16 = 1'b0;
   logic [7:0] held32 = 8'h00, held16 = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   // Reference frame: SOF, bytes MSB first, XOR of data bytes; last entry flagged.
   task automatic model_frame(input bit is16, input logic [31:0] w, input int nb, input bit use_c);
      logic [8:0] q[$];
      logic [7:0] c = 8'h00;
      logic [7:0] b;
      q.push_back({1'b0, 8'hA5});
      for (int i = 0; i < nb; i++) begin
         b = 8'(w >> (8 * (nb - 1 - i)));
         c = c ^ b;
         q.push_back({1'b0, b});
      end
      if (use_c) q.push_back({1'b0, c});
      q[q.size()-1][8] = 1'b1;
      foreach (q[i]) begin
         if (is16) exp16.push_back(q[i]);
         else      exp32.push_back(q[i]);
      end
   endtask

   task automatic drive();
      b32.resp_fifo_valid = (fifo32.size() != 0);
      b32.resp_fifo_data  = (fifo32.size() != 0) ? fifo32[0] : 32'h0;
      b16.resp_fifo_valid = (fifo16.size() != 0);
      b16.resp_fifo_data  = (fifo16.size() != 0) ? fifo16[0] : 16'h0;
   endtask

   task automatic push32(input logic [31:0] w);
      fifo32.push_back(w);
      model_frame(1'b0, w, 4, 1'b1);
      drive();
   endtask

   task automatic push16(input logic [15:0] w);
      fifo16.push_back(w);
      model_frame(1'b1, 32'(w), 2, 1'b0);
      drive();
   endtask

   task automatic step(input bit r32, input bit r16);
      logic [31:0] t32;
      logic [15:0] t16;
      @(posedge clk);
      #1;
      if (pop32 && fifo32.size() != 0) t32 = fifo32.pop_front();
      if (pop16 && fifo16.size() != 0) t16 = fifo16.pop_front();
      b32.tx_ready = r32;
      b16.tx_ready = r16;
      drive();
   endtask

   // mode 0: ready high; 1: ready one cycle in three; 2: random ready
   task automatic drain(input int mode, output int busy_cyc, output int vld_cyc,
                        output int first_v, output int last_v);
      int n = 0;
      bit r;
      busy_cyc = 0; vld_cyc = 0; first_v = -1; last_v = -1;
      while ((exp32.size() != 0 || exp16.size() != 0 || fifo32.size() != 0 ||
              fifo16.size() != 0 || b32.busy || b16.busy) && n < 3000) begin
         r = (mode == 0) ? 1'b1 : (mode == 1) ? (n % 3 == 2) : ($urandom_range(0, 3) != 0);
         step(r, (mode == 2) ? ($urandom_range(0, 2) != 0) : r);
         n++;
         if (b32.busy) busy_cyc++;
         if (b32.tx_valid || b16.tx_valid) begin
            vld_cyc++;
            if (first_v < 0) first_v = n;
            last_v = n;
         end
      end
      if (n >= 3000) begin
         checks++;
         $display("FAIL drain_timeout: got %0d cycles expected fewer than 3000", n);
      end
   endtask

   // Monitor: compares every accepted byte against the scoreboard and checks stall stability.
   initial forever begin
      logic [8:0] e;
      @(negedge clk);
      if (!rst_n) begin
         pop32 = 1'b0; pop16 = 1'b0; stall32 = 1'b0; stall16 = 1'b0;
      end else begin
         pop32 = b32.resp_fifo_rd_en && b32.resp_fifo_valid;
         pop16 = b16.resp_fifo_rd_en && b16.resp_fifo_valid;
         if (b32.resp_fifo_rd_en) begin rd32_cnt++; chk("rd_en_busy32", 32'(b32.busy), 0); end
         if (b16.resp_fifo_rd_en) begin rd16_cnt++; chk("rd_en_busy16", 32'(b16.busy), 0); end
         if (stall32) begin
            chk("stall_valid32", 32'(b32.tx_valid), 1);
            chk("stall_data32", 32'(b32.tx_data), 32'(held32));
         end
         if (stall16) begin
            chk("stall_valid16", 32'(b16.tx_valid), 1);
            chk("stall_data16", 32'(b16.tx_data), 32'(held16));
         end
         if (b32.tx_valid && b32.tx_ready) begin
            hs32_cnt++;
            if (exp32.size() == 0) begin
               checks++;
               $display("FAIL byte32: got %h expected no byte", b32.tx_data);
            end else begin
               e = exp32.pop_front();
               chk("byte32", 32'(b32.tx_data), 32'(e[7:0]));
               chk("frame_done32", 32'(b32.frame_done), 32'(e[8]));
            end
         end else if (b32.frame_done) begin
            checks++;
            $display("FAIL frame_done32: got 1 expected 0 without handshake");
         end
         if (b16.tx_valid && b16.tx_ready) begin
            if (exp16.size() == 0) begin
               checks++;
               $display("FAIL byte16: got %h expected no byte", b16.tx_data);
            end else begin
               e = exp16.pop_front();
               chk("byte16", 32'(b16.tx_data), 32'(e[7:0]));
               chk("frame_done16", 32'(b16.frame_done), 32'(e[8]));
            end
         end else if (b16.frame_done) begin
            checks++;
            $display("FAIL frame_done16: got 1 expected 0 without handshake");
         end
         stall32 = b32.tx_valid && !b32.tx_ready;
         held32  = b32.tx_data;
         stall16 = b16.tx_valid && !b16.tx_ready;
         held16  = b16.tx_data;
      end
   end

   initial begin
      int bc, vc, fv, lv, rd0, np;
      b32.tx_ready = 1'b0;
      b16.tx_ready = 1'b0;
      drive();
      #1;
      chk("reset_tx_valid", 32'(b32.tx_valid), 0);
      chk("reset_tx_data", 32'(b32.tx_data), 0);
      chk("reset_rd_en", 32'(b32.resp_fifo_rd_en), 0);
      chk("reset_busy", 32'(b32.busy), 0);
      chk("reset_frame_done", 32'(b32.frame_done), 0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b1, 1'b1);

      // Single word, ready high: rd_en same cycle, SOF next cycle, busy 6 cycles.
      rd0 = rd32_cnt;
      push32(32'h12345678);
      #1;
      chk("latency_rd_en", 32'(b32.resp_fifo_rd_en), 1);
      chk("latency_tx_valid_low", 32'(b32.tx_valid), 0);
      drain(0, bc, vc, fv, lv);
      chk("single_first_valid", 32'(fv), 1);
      chk("single_busy_cycles", 32'(bc), 6);
      chk("single_valid_cycles", 32'(vc), 6);
      chk("single_rd_pulses", 32'(rd32_cnt - rd0), 1);

      // Same word, ready one cycle in three.
      rd0 = rd32_cnt;
      push32(32'h12345678);
      drain(1, bc, vc, fv, lv);
      chk("stall_rd_pulses", 32'(rd32_cnt - rd0), 1);

      // Back-to-back words: one IDLE bubble between frames.
      rd0 = rd32_cnt;
      push32(32'hFFFFFFFF);
      push32(32'h00000001);
      drain(0, bc, vc, fv, lv);
      chk("b2b_valid_cycles", 32'(vc), 12);
      chk("b2b_span", 32'(lv - fv + 1), 13);
      chk("b2b_rd_pulses", 32'(rd32_cnt - rd0), 2);

      // 16-bit instance without checksum.
      rd0 = rd16_cnt;
      push16(16'hBEEF);
      drain(0, bc, vc, fv, lv);
      chk("w16_valid_cycles", 32'(vc), 3);
      chk("w16_rd_pulses", 32'(rd16_cnt - rd0), 1);

      // Reset after the second data byte; the partial frame is dropped.
      rd0 = hs32_cnt;
      push32(32'hCAFEF00D);
      for (int i = 0; i < 50 && (hs32_cnt - rd0) < 3; i++) step(1'b1, 1'b1);
      chk("reset_point_bytes", 32'(hs32_cnt - rd0), 3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midreset_tx_valid", 32'(b32.tx_valid), 0);
      chk("midreset_busy", 32'(b32.busy), 0);
      chk("midreset_tx_data", 32'(b32.tx_data), 0);
      exp32.delete();
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      rst_n = 1'b1;
      push32(32'h00000000);
      drain(0, bc, vc, fv, lv);
      chk("post_reset_valid_cycles", 32'(vc), 6);

      // Empty FIFO with ready toggling: everything stays quiet.
      for (int i = 0; i < 20; i++) begin
         step(i[0], ~i[0]);
         chk("idle_quiet32", {29'b0, b32.tx_valid, b32.resp_fifo_rd_en, b32.busy}, 0);
         chk("idle_quiet16", {29'b0, b16.tx_valid, b16.resp_fifo_rd_en, b16.busy}, 0);
      end

      // Random words and random backpressure on both instances.
      rd0 = rd32_cnt;
      np = 0;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0 && fifo32.size() < 3) begin
            push32($urandom());
            np++;
         end
         if ($urandom_range(0, 4) == 0 && fifo16.size() < 3) push16(16'($urandom()));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      end
      drain(2, bc, vc, fv, lv);
      chk("rand_rd_pulses", 32'(rd32_cnt - rd0), 32'(np));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
